// File: rtl/spdif_tx_if.sv
// Sample-pair handshake between an audio source and spdif_tx.
// Strict valid/ready: the source holds i_valid and both samples stable until
// a cycle with i_valid && o_ready; that cycle is the transfer.
interface spdif_tx_if #(
    parameter int DATA_BITS = 24
);
    logic                 i_valid;
    logic                 o_ready;
    logic [DATA_BITS-1:0] i_left;
    logic [DATA_BITS-1:0] i_right;

    // Source side drives the samples and valid, sees ready.
    modport master (
        output i_valid,
        output i_left,
        output i_right,
        input  o_ready
    );

    // Transmitter side consumes the samples and valid, drives ready.
    modport slave (
        input  i_valid,
        input  i_left,
        input  i_right,
        output o_ready
    );
endinterface

// File: rtl/spdif_tx.sv
// S/PDIF (IEC 60958 consumer) biphase-mark transmitter.
// Takes 24-bit stereo pairs over spdif_tx_if, frames them into 192-frame
// blocks with B/M/W preambles and V/U/C/P bits, and drives one registered
// line. Every line half-cell takes one i_ce strobe; the handshake is
// evaluated on every clock.
// Optional build macro SPDIF_TX_CHSTAT_EN: when defined, slot 30 carries
// C_STATUS[frame] for frames 0..31 (0 afterwards); when undefined slot 30
// is always 0 and C_STATUS is not used.
module spdif_tx #(
    parameter int          DATA_BITS = 24,
    parameter logic [31:0] C_STATUS  = 32'h0000_0004
) (
    input  logic      i_clk,
    input  logic      i_reset_n,
    input  logic      i_ce,
    spdif_tx_if.slave s_if,
    output logic      o_spdif,
    output logic      o_block_start,
    output logic      o_underrun
);
    // Preambles, first half-cell in the MSB, relative to a previous level of 0.
    localparam logic [7:0] PRE_B      = 8'b1110_1000;
    localparam logic [7:0] PRE_M      = 8'b1110_0010;
    localparam logic [7:0] PRE_W      = 8'b1110_0100;
    localparam logic [7:0] LAST_FRAME = 8'd191;

    // Position within the block.
    logic [5:0]           hc_q, hc_d;          // half-cell 0..63 of the subframe
    logic                 sub_q, sub_d;        // 0 = left, 1 = right
    logic [7:0]           frame_q, frame_d;    // frame 0..191

    // Holding register filled by the handshake.
    logic                 hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0] hold_l_q, hold_l_d;
    logic [DATA_BITS-1:0] hold_r_q, hold_r_d;

    // Shift registers for the frame on the line, LSB leaves first.
    logic [DATA_BITS-1:0] sh_l_q, sh_l_d;
    logic [DATA_BITS-1:0] sh_r_q, sh_r_d;
    logic                 v_q, v_d;            // validity flag for this frame

    // Line coding state.
    logic                 lvl_q, lvl_d;        // line level before the current preamble
    logic                 par_q, par_d;        // running parity of slots 4..30
    logic                 spdif_q, spdif_d;
    logic                 block_q, block_d;
    logic                 under_q, under_d;

    // Combinational helpers.
    logic                 accept;
    logic                 frame_load;
    logic [4:0]           slot;
    logic                 data_bit;
    logic                 c_bit;
    logic                 slot_bit;
    logic [7:0]           pre_pat;
    logic                 pre_ref;
    logic                 line_bit;

    assign s_if.o_ready  = ~hold_full_q;
    assign o_spdif       = spdif_q;
    assign o_block_start = block_q;
    assign o_underrun    = under_q;

    // Handshake and frame-load qualifiers; a load at the same edge as a
    // transfer into an empty holding register still sees it empty.
    always_comb begin
        accept     = s_if.i_valid && ~hold_full_q;
        frame_load = i_ce && (hc_q == 6'd0) && ~sub_q;
        slot       = hc_q[5:1];
    end

`ifdef SPDIF_TX_CHSTAT_EN
    // Channel status: one bit per frame for the first 32 frames of a block.
    always_comb begin
        c_bit = 1'b0;
        if (frame_q < 8'd32) begin
            c_bit = C_STATUS[frame_q[4:0]];
        end
    end
`else
    logic unused_c_status;
    assign unused_c_status = ^C_STATUS;

    // Channel status disabled: slot 30 is a constant zero.
    always_comb begin
        c_bit = 1'b0;
    end
`endif

    // Logical value of the slot currently on the line.
    always_comb begin
        data_bit = sub_q ? sh_r_q[0] : sh_l_q[0];
        case (slot)
            5'd28:   slot_bit = v_q;
            5'd29:   slot_bit = 1'b0;
            5'd30:   slot_bit = c_bit;
            5'd31:   slot_bit = par_q;
            default: slot_bit = data_bit;
        endcase
    end

    // Next line level: preamble relative to the level before it, then
    // biphase mark (transition at every slot start, extra one mid-slot for '1').
    always_comb begin
        if (sub_q) begin
            pre_pat = PRE_W;
        end else if (frame_q == 8'd0) begin
            pre_pat = PRE_B;
        end else begin
            pre_pat = PRE_M;
        end
        pre_ref = (hc_q == 6'd0) ? spdif_q : lvl_q;
        if (hc_q < 6'd8) begin
            line_bit = pre_pat[3'd7 - hc_q[2:0]] ^ pre_ref;
        end else if (~hc_q[0]) begin
            line_bit = ~spdif_q;
        end else begin
            line_bit = slot_bit ? ~spdif_q : spdif_q;
        end
    end

    // Next-state logic: handshake every cycle, everything else on i_ce.
    always_comb begin
        hc_d        = hc_q;
        sub_d       = sub_q;
        frame_d     = frame_q;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        sh_l_d      = sh_l_q;
        sh_r_d      = sh_r_q;
        v_d         = v_q;
        lvl_d       = lvl_q;
        par_d       = par_q;
        spdif_d     = spdif_q;
        block_d     = 1'b0;
        under_d     = 1'b0;

        // A full holding register is emptied by the frame load; an empty one
        // accepts the next pair. The two cannot happen on the same edge.
        if (frame_load && hold_full_q) begin
            hold_full_d = 1'b0;
        end else if (accept) begin
            hold_full_d = 1'b1;
            hold_l_d    = s_if.i_left;
            hold_r_d    = s_if.i_right;
        end

        if (i_ce) begin
            spdif_d = line_bit;
            hc_d    = hc_q + 6'd1;

            if (hc_q == 6'd63) begin
                sub_d = ~sub_q;
                if (sub_q) begin
                    frame_d = (frame_q == LAST_FRAME) ? 8'd0 : frame_q + 8'd1;
                end
            end

            // Remember the level the preamble is referenced to.
            if (hc_q == 6'd0) begin
                lvl_d = spdif_q;
            end

            // Parity restarts with slot 4 and absorbs each slot up to 30 at
            // its midpoint half-cell.
            if (hc_q == 6'd8) begin
                par_d = 1'b0;
            end else if (hc_q[0] && (hc_q > 6'd8) && (slot != 5'd31)) begin
                par_d = par_q ^ slot_bit;
            end

            // Advance the active sample once its bit has been sent.
            if (hc_q[0] && (hc_q > 6'd8) && (slot < 5'd28)) begin
                if (sub_q) begin
                    sh_r_d = sh_r_q >> 1;
                end else begin
                    sh_l_d = sh_l_q >> 1;
                end
            end

            if (frame_load) begin
                block_d = (frame_q == 8'd0);
                if (hold_full_q) begin
                    sh_l_d = hold_l_q;
                    sh_r_d = hold_r_q;
                    v_d    = 1'b0;
                end else begin
                    sh_l_d  = '0;
                    sh_r_d  = '0;
                    v_d     = 1'b1;
                    under_d = 1'b1;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hc_q        <= 6'd0;
            sub_q       <= 1'b0;
            frame_q     <= 8'd0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            sh_l_q      <= '0;
            sh_r_q      <= '0;
            v_q         <= 1'b0;
            lvl_q       <= 1'b0;
            par_q       <= 1'b0;
            spdif_q     <= 1'b0;
            block_q     <= 1'b0;
            under_q     <= 1'b0;
        end else begin
            hc_q        <= hc_d;
            sub_q       <= sub_d;
            frame_q     <= frame_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            sh_l_q      <= sh_l_d;
            sh_r_q      <= sh_r_d;
            v_q         <= v_d;
            lvl_q       <= lvl_d;
            par_q       <= par_d;
            spdif_q     <= spdif_d;
            block_q     <= block_d;
            under_q     <= under_d;
        end
    end
endmodule

// File: doc/spdif_tx.md
Name: spdif_tx

Overview:
- S/PDIF (IEC 60958 consumer) biphase-mark transmitter, the transmit counterpart of the PLL-based S/PDIF receive path.
- Accepts 24-bit stereo sample pairs over a valid/ready handshake.
- Frames them into 192-frame blocks with B/M/W preambles, V/U/C/P bits and biphase-mark line coding.
- Drives one serial line output, advanced by a half-cell clock enable derived from the system clock (nominally 44100*2*32*2 enables per second).

Parameters:
- DATA_BITS, 24, audio word width; fixed at 24, slots 4-27, LSB first
- C_STATUS, 32'h0000_0004, channel-status bits 0..31 (bit n sent in frame n); bits 32..191 always 0

Ports:
- i_clk  input  1  system clock
- i_reset_n  input  1  asynchronous active-low reset
- i_ce  input  1  half-cell strobe; one line half-cell per asserted cycle
- i_valid  input  1  sample pair valid
- o_ready  output  1  holding register empty; transfer occurs when i_valid && o_ready
- i_left  input  24  left sample, two's complement
- i_right  input  24  right sample, two's complement
- o_spdif  output  1  biphase-mark line output, registered
- o_block_start  output  1  one-cycle pulse on the i_ce cycle emitting half-cell 0 of frame 0
- o_underrun  output  1  one-cycle pulse when a frame starts with the holding register empty

Behaviour:
- All state advances only on cycles with i_ce=1. Exception: the handshake is evaluated every cycle.
- Reset values:
  - o_spdif=0, o_ready=1, o_block_start=0, o_underrun=0
  - half-cell counter=0, subframe=left, frame counter=0
  - shift data=0
- Counters:
  - half-cell counter 0..63 per subframe; wraps to 0 and toggles left/right.
  - frame counter 0..191, incremented after each right subframe; wraps 191->0.
- Preamble, half-cells 0..7, level-relative to previous line level L:
  - frame 0 left = B 11101000
  - other left = M 11100010
  - right = W 11100100
  - Send pattern as-is if L=0, inverted if L=1.
- Slots 4..31 (half-cells 8..63): biphase mark.
  - Every slot starts with a transition.
  - A '1' adds a transition at the slot midpoint (odd half-cell).
- Slot contents:
  - 4..27: sample LSB first
  - 28: V
  - 29: U=0
  - 30: C
  - 31: P, chosen so that slots 4..31 contain an even number of ones
- Parity is accumulated serially and reset at half-cell 8.
- Frame load, on the i_ce cycle at half-cell 0 of a left subframe:
  - If holding full: copy left/right into the shift registers, V=0, holding becomes empty (o_ready=1 next cycle).
  - If holding empty: shift registers load 0, V=1 for both subframes, o_underrun pulses.
- Simultaneous handshake and frame load, holding empty: the handshake is not forwarded.
  - The frame underruns.
  - The new pair is stored and used at the next frame.
- Holding register: written when i_valid && o_ready; o_ready drops the following cycle.
  - Holding the full pair through the frame lets upstream refill during 128 half-cells.
- Latency:
  - o_spdif changes one cycle after the i_ce cycle that selects it.
  - First edge after reset is the first B half-cell ('1') on the cycle after the first i_ce.
- Mid-operation reset: all of the above returns to reset values immediately; the next frame after release is frame 0 with B.
- i_ce held low: o_spdif holds its level; handshake still accepts one pair.

Optional Feature:
- Macro: SPDIF_TX_CHSTAT_EN.
- Defined: slot 30 carries C_STATUS[frame] for frames 0..31 and 0 for frames 32..191, identical in left and right subframes.
- Undefined: slot 30 is always 0, C_STATUS is ignored, and the frame-indexed mux is removed.
- Parity covers slot 30 in both cases.

Test Plan:
- Reset then i_ce every cycle, no samples:
  - first 8 half-cells 11101000
  - o_underrun pulses at half-cell 0 of every frame
  - V=1, data all zero
  - P=1 (V alone gives odd count)
- One pair L=24'h000001, R=24'h800000 before the first frame start, then none:
  - decoded left slot 4=1 and slots 5..27=0
  - right slot 27=1
  - both V=0 and P=1
  - next frame underruns
- Continuous pairs L=24'hA5A5A5, R=24'h5A5A5A:
  - receiver-model decode matches every frame
  - o_ready low between load and frame start
  - no underrun
  - o_block_start every 24576 cycles
- Level check: force a subframe ending high (odd data parity path); the next preamble is inverted (e.g., M = 00011101).
- SPDIF_TX_CHSTAT_EN with C_STATUS=32'h0000_0004:
  - C=1 only in frame 2, both subframes
  - parity correct
  - macro undefined gives C=0 in frame 2
- Assert i_reset_n low mid-subframe (half-cell 40) for 3 cycles:
  - o_spdif=0, o_ready=1
  - restart sends B and frame 0
